// File: rtl/adc_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// adc_sample_fifo_if
// Wishbone slave register window for adc_sample_fifo.
//
// Signals:
//   WBS_CYC, WBS_STB     cycle / strobe from the interconnect
//   WBS_WE, WBS_RD       write enable / read enable
//   WBS_BYTE_STB[3:0]    byte enables (writes only)
//   WBS_ADR              local byte address (register = WBS_ADR[7:2])
//   WBS_WR_DAT           write data
//   WBS_RD_DAT           registered read data, valid with WBS_ACK
//   WBS_ACK              single-cycle transfer acknowledge
// Modports: master (interconnect side), slave (FIFO side).
// -----------------------------------------------------------------------------
interface adc_sample_fifo_if #(
  parameter int ADDR_WIDTH     = 17,
  parameter int MUX_ADDR_WIDHT = 9,
  parameter int DATA_WIDTH     = 32
);
  logic                               WBS_CYC;
  logic                               WBS_STB;
  logic                               WBS_WE;
  logic                               WBS_RD;
  logic [3:0]                         WBS_BYTE_STB;
  logic [ADDR_WIDTH-MUX_ADDR_WIDHT-1:0] WBS_ADR;
  logic [DATA_WIDTH-1:0]              WBS_WR_DAT;
  logic [DATA_WIDTH-1:0]              WBS_RD_DAT;
  logic                               WBS_ACK;

  modport master (
    output WBS_CYC, WBS_STB, WBS_WE, WBS_RD, WBS_BYTE_STB, WBS_ADR, WBS_WR_DAT,
    input  WBS_RD_DAT, WBS_ACK
  );

  modport slave (
    input  WBS_CYC, WBS_STB, WBS_WE, WBS_RD, WBS_BYTE_STB, WBS_ADR, WBS_WR_DAT,
    output WBS_RD_DAT, WBS_ACK
  );
endinterface

// File: rtl/adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// adc_sample_fifo
// Buffers 16-bit ADC samples in a synchronous word FIFO, raises an SDMA request
// when the fill level reaches a programmable threshold, and lets the DMA/CPU
// drain words through a Wishbone register window.
//
// Ports:
//   WB_CLK, WB_RST    clock, synchronous active-high reset
//   wbs               Wishbone slave (adc_sample_fifo_if.slave)
//   ADC_DATA          sample from the AD7984 capture block
//   ADC_DATA_VALID    one-cycle sample strobe
//   SDMA_REQ          registered DMA request
//   SDMA_DONE         one-cycle DMA-done pulse (sets DONE)
//   SDMA_ACTIVE       DMA channel active (informational, unused)
//   FIFO_IRQ          |(sticky {UNF,OVF,DONE} & CTRL mask)
//
// Registers (byte offsets): 0x00 CTRL, 0x04 STATUS, 0x08 THRESH, 0x0C DATA.
//
// Build option: define ADC_FIFO_PACK_EN to pack two samples per 32-bit word;
// without it every sample is pushed as {16'h0, sample}.
// -----------------------------------------------------------------------------
module adc_sample_fifo #(
  parameter int ADDR_WIDTH     = 17,
  parameter int MUX_ADDR_WIDHT = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int FIFO_DEPTH     = 256
) (
  input  logic                    WB_CLK,
  input  logic                    WB_RST,
  adc_sample_fifo_if.slave        wbs,
  input  logic [SAMPLE_WIDTH-1:0] ADC_DATA,
  input  logic                    ADC_DATA_VALID,
  output logic                    SDMA_REQ,
  input  logic                    SDMA_DONE,
  input  logic                    SDMA_ACTIVE,
  output logic                    FIFO_IRQ
);
  localparam int LW       = $clog2(FIFO_DEPTH);
  localparam int LOCAL_AW = ADDR_WIDTH - MUX_ADDR_WIDHT;

  localparam logic [LW:0] FULL_LEVEL = (LW+1)'(FIFO_DEPTH);
  localparam logic [LW:0] THRESH_RST = (LW+1)'(FIFO_DEPTH / 2);

  localparam logic [5:0] REG_CTRL   = 6'h0;
  localparam logic [5:0] REG_STATUS = 6'h1;
  localparam logic [5:0] REG_THRESH = 6'h2;
  localparam logic [5:0] REG_DATA   = 6'h3;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [3:0]            stb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (stb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic [2:0]            ctrl_mask_q, ctrl_mask_d;
  logic [LW:0]           thresh_q, thresh_d;
  logic [LW:0]           count_q, count_d;
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  sdma_req_q, sdma_req_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [LOCAL_AW-1:0]   local_adr;
  logic [5:0]            reg_sel;
  logic                  access, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] ctrl_merged, thresh_merged, status_word;
  logic [2:0]            sticky_clr;
  logic                  flush, pop_fire, unf_evt, ovf_evt, push_ok, full;
  logic                  push_req;
  logic [DATA_WIDTH-1:0] push_word;

  assign local_adr = wbs.WBS_ADR;
  assign reg_sel   = local_adr[7:2];
  // A new access is only taken while ACK is low, so every ack carries exactly
  // one set of side effects and acks can never be back-to-back.
  assign access    = wbs.WBS_CYC & wbs.WBS_STB & ~ack_q;
  assign wr_en     = access & wbs.WBS_WE;
  assign rd_en     = access & ~wbs.WBS_WE & wbs.WBS_RD;
  assign full      = (count_q == FULL_LEVEL);

`ifdef ADC_FIFO_PACK_EN
  logic                    phase_q, phase_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;

  // Pair samples into {new, held}; the phase is cleared while ingest is off
  // or on flush so a stale half-word never ends up in a later word.
  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    phase_d   = phase_q;
    hold_d    = hold_q;
    if (!ctrl_en_q || flush) begin
      phase_d = 1'b0;
    end else if (ADC_DATA_VALID) begin
      if (!phase_q) begin
        hold_d  = ADC_DATA;
        phase_d = 1'b1;
      end else begin
        push_req  = 1'b1;
        push_word = {ADC_DATA, hold_q};
        phase_d   = 1'b0;
      end
    end
  end

  // Pack state register.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      phase_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end
`else
  // One word per sample, zero-extended into the upper half.
  always_comb begin
    push_req  = ctrl_en_q & ADC_DATA_VALID;
    push_word = DATA_WIDTH'(ADC_DATA);
  end
`endif

  // Register writes, reads with their side effects, and FIFO bookkeeping.
  always_comb begin
    ack_d       = access;
    rd_dat_d    = rd_dat_q;
    ctrl_en_d   = ctrl_en_q;
    ctrl_mask_d = ctrl_mask_q;
    thresh_d    = thresh_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    flush       = 1'b0;
    pop_fire    = 1'b0;
    unf_evt     = 1'b0;
    sticky_clr  = 3'b000;

    ctrl_merged   = merge_bytes(DATA_WIDTH'({ctrl_mask_q, 1'b0, ctrl_en_q}),
                                wbs.WBS_WR_DAT, wbs.WBS_BYTE_STB);
    thresh_merged = merge_bytes(DATA_WIDTH'(thresh_q), wbs.WBS_WR_DAT, wbs.WBS_BYTE_STB);

    status_word       = DATA_WIDTH'(count_q);
    status_word[16]   = (count_q == '0);
    status_word[17]   = full;
    status_word[24]   = done_q;
    status_word[25]   = ovf_q;
    status_word[26]   = unf_q;

    if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          ctrl_en_d   = ctrl_merged[0];
          ctrl_mask_d = ctrl_merged[4:2];
          flush       = ctrl_merged[1];
        end
        REG_STATUS: begin
          if (wbs.WBS_BYTE_STB[3]) sticky_clr = wbs.WBS_WR_DAT[26:24];
        end
        REG_THRESH: thresh_d = thresh_merged[LW:0];
        default: ;
      endcase
    end

    if (rd_en) begin
      case (reg_sel)
        REG_CTRL:   rd_dat_d = DATA_WIDTH'({ctrl_mask_q, 1'b0, ctrl_en_q});
        REG_STATUS: rd_dat_d = status_word;
        REG_THRESH: rd_dat_d = DATA_WIDTH'(thresh_q);
        REG_DATA: begin
          if (count_q != '0) begin
            rd_dat_d = mem_q[rd_ptr_q];
            pop_fire = 1'b1;
          end else begin
            rd_dat_d = '0;
            unf_evt  = 1'b1;
          end
        end
        default: rd_dat_d = '0;
      endcase
    end

    // A pop in the same cycle frees the slot, so a push at full still fits.
    push_ok = push_req && !flush && (!full || pop_fire);
    ovf_evt = push_req && !flush && full && !pop_fire;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (LW+1)'(push_ok) - (LW+1)'(pop_fire);
    end

    // Setting events win over a W1C in the same cycle.
    done_d = (done_q & ~sticky_clr[0]) | SDMA_DONE;
    ovf_d  = (ovf_q  & ~sticky_clr[1]) | ovf_evt;
    unf_d  = (unf_q  & ~sticky_clr[2]) | unf_evt;

    sdma_req_d = ctrl_en_q && (count_q >= thresh_q) && (count_q != '0);
  end

  // Control and status state register.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      ack_q       <= 1'b0;
      rd_dat_q    <= '0;
      ctrl_en_q   <= 1'b0;
      ctrl_mask_q <= 3'b000;
      thresh_q    <= THRESH_RST;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      sdma_req_q  <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      rd_dat_q    <= rd_dat_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_mask_q <= ctrl_mask_d;
      thresh_q    <= thresh_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      sdma_req_q  <= sdma_req_d;
    end
  end

  // Storage has no reset; contents are don't-care until written.
  always_ff @(posedge WB_CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign wbs.WBS_ACK    = ack_q;
  assign wbs.WBS_RD_DAT = rd_dat_q;
  assign SDMA_REQ       = sdma_req_q;
  assign FIFO_IRQ       = |({unf_q, ovf_q, done_q} & ctrl_mask_q);

  logic unused_sink;
  assign unused_sink = ^{SDMA_ACTIVE, local_adr[1:0],
                         ctrl_merged[DATA_WIDTH-1:5], thresh_merged[DATA_WIDTH-1:LW+1]};
endmodule

// File: tb/tb_adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_fifo
// Self-checking bench for adc_sample_fifo. A behavioural model (word queue,
// held half-word, sticky flags) predicts every register read, the DMA request
// and the interrupt. Directed scenarios are followed by a randomized mix.
// Works with and without ADC_FIFO_PACK_EN.
// -----------------------------------------------------------------------------
module tb_adc_sample_fifo;
  localparam int ADDR_WIDTH     = 17;
  localparam int MUX_ADDR_WIDHT = 9;
  localparam int DATA_WIDTH     = 32;
  localparam int SAMPLE_WIDTH   = 16;
  localparam int FIFO_DEPTH     = 256;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_THRESH = 8'h08;
  localparam logic [7:0] A_DATA   = 8'h0C;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        sdma_req;
  logic        sdma_done;
  logic        sdma_active;
  logic        fifo_irq;

  adc_sample_fifo_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .MUX_ADDR_WIDHT(MUX_ADDR_WIDHT), .DATA_WIDTH(DATA_WIDTH)
  ) wbs_if ();

  adc_sample_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH), .MUX_ADDR_WIDHT(MUX_ADDR_WIDHT), .DATA_WIDTH(DATA_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .WB_CLK(clk),
    .WB_RST(rst),
    .wbs(wbs_if),
    .ADC_DATA(adc_data),
    .ADC_DATA_VALID(adc_valid),
    .SDMA_REQ(sdma_req),
    .SDMA_DONE(sdma_done),
    .SDMA_ACTIVE(sdma_active),
    .FIFO_IRQ(fifo_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] m_q[$];
  logic        m_en;
  logic [2:0]  m_mask;
  int          m_thresh;
  logic        m_done, m_ovf, m_unf;
  logic        m_phase;
  logic [15:0] m_held;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] stb);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (stb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelStatus();
    int lvl = m_q.size();
    logic [31:0] s = 32'(lvl);
    if (lvl == 0) s[16] = 1'b1;
    if (lvl == FIFO_DEPTH) s[17] = 1'b1;
    s[24] = m_done;
    s[25] = m_ovf;
    s[26] = m_unf;
    return s;
  endfunction

  function automatic logic modelReq();
    return m_en && (m_q.size() >= m_thresh) && (m_q.size() != 0);
  endfunction

  function automatic logic modelIrq();
    return |({m_unf, m_ovf, m_done} & m_mask);
  endfunction

  function automatic void modelPushWord(input logic [31:0] w);
    if (m_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
    else m_q.push_back(w);
  endfunction

  function automatic void modelSample(input logic [15:0] s);
    if (!m_en) return;
`ifdef ADC_FIFO_PACK_EN
    if (!m_phase) begin
      m_held  = s;
      m_phase = 1'b1;
    end else begin
      modelPushWord({s, m_held});
      m_phase = 1'b0;
    end
`else
    modelPushWord({16'h0, s});
`endif
  endfunction

  function automatic void modelWrite(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] stb);
    logic [31:0] m;
    case (addr)
      A_CTRL: begin
        m = mergeBytes({27'b0, m_mask, 1'b0, m_en}, d, stb);
        m_en   = m[0];
        m_mask = m[4:2];
        if (!m_en) m_phase = 1'b0;
        if (m[1]) begin
          m_q.delete();
          m_phase = 1'b0;
        end
      end
      A_STATUS: if (stb[3]) begin
        if (d[24]) m_done = 1'b0;
        if (d[25]) m_ovf  = 1'b0;
        if (d[26]) m_unf  = 1'b0;
      end
      A_THRESH: begin
        m = mergeBytes(32'(m_thresh), d, stb);
        m_thresh = int'(m[8:0]);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] addr);
    case (addr)
      A_CTRL:   return {27'b0, m_mask, 1'b0, m_en};
      A_STATUS: return modelStatus();
      A_THRESH: return 32'(m_thresh);
      A_DATA: begin
        if (m_q.size() != 0) return m_q.pop_front();
        m_unf = 1'b1;
        return 32'h0;
      end
      default:  return 32'h0;
    endcase
  endfunction

  task automatic busIdle();
    wbs_if.WBS_CYC = 1'b0;
    wbs_if.WBS_STB = 1'b0;
    wbs_if.WBS_WE  = 1'b0;
    wbs_if.WBS_RD  = 1'b0;
  endtask

  task automatic waitAck(input string tag, input int already);
    int waited = already;
    while (!wbs_if.WBS_ACK && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, 32'(wbs_if.WBS_ACK), 32'd1);
  endtask

  task automatic wbWrite(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] stb);
    @(negedge clk);
    wbs_if.WBS_CYC = 1'b1; wbs_if.WBS_STB = 1'b1; wbs_if.WBS_WE = 1'b1; wbs_if.WBS_RD = 1'b0;
    wbs_if.WBS_ADR = addr; wbs_if.WBS_WR_DAT = d; wbs_if.WBS_BYTE_STB = stb;
    waitAck("wr_ack", 0);
    busIdle();
    modelWrite(addr, d, stb);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr);
    logic        exp_req = modelReq();
    logic [31:0] got, exp;
    @(negedge clk);
    wbs_if.WBS_CYC = 1'b1; wbs_if.WBS_STB = 1'b1; wbs_if.WBS_WE = 1'b0; wbs_if.WBS_RD = 1'b1;
    wbs_if.WBS_ADR = addr; wbs_if.WBS_BYTE_STB = 4'h0;
    waitAck("rd_ack", 0);
    got = wbs_if.WBS_RD_DAT;
    busIdle();
    checkOutput("req_rd", 32'(sdma_req), 32'(exp_req));
    exp = modelRead(addr);
    checkOutput(tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [15:0] s);
    logic exp_req = modelReq();
    @(negedge clk);
    adc_data  = s;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    modelSample(s);
    checkOutput("req_lag", 32'(sdma_req), 32'(exp_req));
  endtask

  task automatic popAndPush(input logic [15:0] s);
    logic [31:0] got, exp;
    @(negedge clk);
    adc_data = s; adc_valid = 1'b1;
    wbs_if.WBS_CYC = 1'b1; wbs_if.WBS_STB = 1'b1; wbs_if.WBS_WE = 1'b0; wbs_if.WBS_RD = 1'b1;
    wbs_if.WBS_ADR = A_DATA;
    @(negedge clk);
    adc_valid = 1'b0;
    waitAck("pp_ack", 1);
    got = wbs_if.WBS_RD_DAT;
    busIdle();
    exp = modelRead(A_DATA);
    modelSample(s);
    checkOutput("pp_data", got, exp);
  endtask

  task automatic pulseDone();
    @(negedge clk);
    sdma_done = 1'b1;
    @(negedge clk);
    sdma_done = 1'b0;
    m_done = 1'b1;
    checkOutput("irq_after_done", 32'(fifo_irq), 32'(modelIrq()));
  endtask

  task automatic checkReqIdle(input string tag);
    @(negedge clk);
    checkOutput(tag, 32'(sdma_req), 32'(modelReq()));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    int op;
    rst = 1'b1;
    adc_data = '0; adc_valid = 1'b0; sdma_done = 1'b0; sdma_active = 1'b0;
    wbs_if.WBS_ADR = '0; wbs_if.WBS_WR_DAT = '0; wbs_if.WBS_BYTE_STB = '0;
    busIdle();
    m_en = 0; m_mask = 0; m_thresh = FIFO_DEPTH / 2;
    m_done = 0; m_ovf = 0; m_unf = 0; m_phase = 0; m_held = 0;

    // Reset with a transfer pending: no ack may appear.
    wbs_if.WBS_CYC = 1'b1; wbs_if.WBS_STB = 1'b1; wbs_if.WBS_RD = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", 32'(wbs_if.WBS_ACK), 32'd0);
    checkOutput("rst_rd_dat", wbs_if.WBS_RD_DAT, 32'd0);
    checkOutput("rst_req", 32'(sdma_req), 32'd0);
    checkOutput("rst_irq", 32'(fifo_irq), 32'd0);
    busIdle();
    rst = 1'b0;

    $display("[TB] reset register values");
    readCheck("rst_ctrl_model", A_CTRL);
    readCheck("rst_status_model", A_STATUS);
    readCheck("rst_thresh_model", A_THRESH);
    checkOutput("rst_thresh_lit", 32'(m_thresh), 32'h80);
    readCheck("unmapped_rd", 8'h10);
    wbWrite(8'h14, 32'hFFFF_FFFF, 4'hF);
    readCheck("ctrl_after_unmapped_wr", A_CTRL);

    $display("[TB] basic ingest and drain");
    wbWrite(A_CTRL, 32'h1, 4'hF);
    applyStimulus(16'h1111); applyStimulus(16'h2222);
    applyStimulus(16'h3333); applyStimulus(16'h4444);
    readCheck("level_after_4", A_STATUS);
    guard = 0;
    while (m_q.size() != 0 && guard < 8) begin
      readCheck("drain", A_DATA);
      guard++;
    end
    readCheck("pop_empty", A_DATA);
    readCheck("unf_status", A_STATUS);
    wbWrite(A_STATUS, 32'h0400_0000, 4'h8);
    readCheck("unf_cleared", A_STATUS);

    $display("[TB] threshold request");
    wbWrite(A_THRESH, 32'h4, 4'hF);
    for (int i = 0; i < 8; i++) applyStimulus(16'h0100 + 16'(i));
    checkReqIdle("req_high");
    guard = 0;
    while (m_q.size() > 3 && guard < 16) begin
      readCheck("thr_pop", A_DATA);
      guard++;
    end
    checkReqIdle("req_below_thresh");

    $display("[TB] fill to full and overflow");
    wbWrite(A_CTRL, 32'h3, 4'hF);
    guard = 0;
    while (m_q.size() < FIFO_DEPTH && guard < 4 * FIFO_DEPTH) begin
      applyStimulus(16'(guard));
      guard++;
    end
    applyStimulus(16'hDEAD);
    applyStimulus(16'hBEEF);
    readCheck("full_status", A_STATUS);
    checkOutput("full_ovf_model", {31'b0, m_ovf}, 32'd1);
    readCheck("first_word_after_ovf", A_DATA);
    wbWrite(A_STATUS, 32'h0200_0000, 4'h8);

    $display("[TB] EN clear discards held half");
    wbWrite(A_CTRL, 32'h3, 4'hF);
    readCheck("ctrl_flush_reads_0", A_CTRL);
    applyStimulus(16'hAAAA);
    wbWrite(A_CTRL, 32'h0, 4'hF);
    wbWrite(A_CTRL, 32'h1, 4'hF);
    applyStimulus(16'hBBBB);
    applyStimulus(16'hCCCC);
    readCheck("en_toggle_status", A_STATUS);
    guard = 0;
    while (m_q.size() != 0 && guard < 8) begin
      readCheck("en_toggle_word", A_DATA);
      guard++;
    end

    $display("[TB] DONE interrupt and simultaneous push/pop");
    wbWrite(A_CTRL, 32'h5, 4'hF);
    checkOutput("irq_masked_idle", 32'(fifo_irq), 32'(modelIrq()));
    pulseDone();
    wbWrite(A_STATUS, 32'h0100_0000, 4'hF);
    checkOutput("irq_after_w1c", 32'(fifo_irq), 32'(modelIrq()));
    wbWrite(A_CTRL, 32'h7, 4'hF);
    guard = 0;
    while (m_q.size() < 5 && guard < 20) begin
      applyStimulus(16'h5000 + 16'(guard));
      guard++;
    end
`ifdef ADC_FIFO_PACK_EN
    applyStimulus(16'h5A5A);
`endif
    popAndPush(16'h6B6B);
    readCheck("level_after_pp", A_STATUS);
    checkOutput("level_pp_model", 32'(m_q.size()), 32'd5);

    $display("[TB] byte-enable write to THRESH");
    wbWrite(A_THRESH, 32'h4, 4'hF);
    wbWrite(A_THRESH, 32'hFFFF_01FF, 4'b0010);
    readCheck("thresh_byte1", A_THRESH);

    $display("[TB] randomized traffic");
    wbWrite(A_CTRL, 32'h3 | (32'($urandom_range(0, 7)) << 2), 4'hF);
    wbWrite(A_STATUS, 32'h0700_0000, 4'h8);
    wbWrite(A_THRESH, 32'($urandom_range(1, 12)), 4'hF);
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 11));
      if (op < 6) applyStimulus(16'($urandom));
      else if (op < 9) readCheck("rnd_pop", A_DATA);
      else if (op == 9) readCheck("rnd_status", A_STATUS);
      else if (op == 10) wbWrite(A_THRESH, 32'($urandom_range(0, 20)), 4'b0001);
      else if ($urandom_range(0, 1) == 1) pulseDone();
      else wbWrite(A_STATUS, {5'b0, 3'($urandom), 24'h0}, 4'b1000);
      checkOutput("rnd_irq", 32'(fifo_irq), 32'(modelIrq()));
    end
    checkReqIdle("rnd_req_final");
    readCheck("rnd_status_final", A_STATUS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_sample_fifo.md
Name: adc_sample_fifo

Overview:
Sample buffer between the AD7984 capture block and the SDMA channel. It accepts 16-bit samples on the ADC_DATA/ADC_DATA_VALID strobe and packs them into 32-bit words in a synchronous FIFO. It raises an SDMA request once the fill level reaches a programmable threshold. The DMA or CPU drains words through a Wishbone slave register window on the interconnect.

Parameters:
ADDR_WIDTH, 17, full Wishbone address width
MUX_ADDR_WIDHT, 9, interconnect select bits; local address = ADDR_WIDTH-MUX_ADDR_WIDHT bits
DATA_WIDTH, 32, Wishbone data width
SAMPLE_WIDTH, 16, ADC sample width
FIFO_DEPTH, 256, FIFO depth in 32-bit words; power of two; LW = log2(FIFO_DEPTH)

Ports:
WB_CLK  in  1  single clock for bus and datapath
WB_RST  in  1  synchronous, active-high reset
WBS_CYC  in  1  Wishbone cycle
WBS_STB  in  1  Wishbone strobe
WBS_WE  in  1  write enable
WBS_RD  in  1  read enable
WBS_BYTE_STB  in  4  byte enables (writes only; reads ignore)
WBS_ADR  in  ADDR_WIDTH-MUX_ADDR_WIDHT  local byte address; register = WBS_ADR[7:2]
WBS_WR_DAT  in  DATA_WIDTH  write data
WBS_RD_DAT  out  DATA_WIDTH  read data
WBS_ACK  out  1  transfer acknowledge
ADC_DATA  in  SAMPLE_WIDTH  sample from AD7984 block
ADC_DATA_VALID  in  1  one-cycle sample strobe
SDMA_REQ  out  1  DMA request
SDMA_DONE  in  1  one-cycle DMA-done pulse
SDMA_ACTIVE  in  1  DMA channel active
FIFO_IRQ  out  1  interrupt = |(STATUS sticky bits & CTRL irq mask)

Behaviour:
- Registers:
  - 0x00 CTRL: [0] EN; [1] FLUSH (self-clearing, reads 0); [4:2] IRQ mask for {UNF, OVF, DONE}.
  - 0x04 STATUS (RO except W1C): [LW:0] level; [16] empty; [17] full; [24] DONE sticky W1C; [25] OVF sticky W1C; [26] UNF sticky W1C.
  - 0x08 THRESH: [LW:0], reset value FIFO_DEPTH/2.
  - 0x0C DATA: read pops one word.
  - Other offsets read 0; writes to them are ignored.
- Wishbone:
  - WBS_ACK pulses for 1 cycle, asserted the cycle after CYC&STB while ACK is low, so there are no back-to-back acks.
  - WBS_RD_DAT is registered and valid with ACK.
  - Side effects (pop, W1C, FLUSH) occur exactly once per ack.
  - Writes honour WBS_BYTE_STB per byte.
- Packing (ADC_FIFO_PACK_EN defined):
  - A sample with pack phase 0 is stored in the low half.
  - A sample with pack phase 1 forms {new, held}, pushes the word, and returns the phase to 0.
- Ingest gating: samples are ignored while EN=0. Clearing EN resets the pack phase and discards a held half-word.
- Push on full: the word is dropped, OVF is set, and FIFO contents are unchanged.
- Pop on empty: read returns 32'h0, UNF is set, and the level stays 0.
- Simultaneous push and pop: both happen, and the level is unchanged.
- Pointers: LW-bit, wrap at FIFO_DEPTH. Level is LW+1 bits, 0..FIFO_DEPTH.
- FLUSH write: next cycle level=0, pointers=0, pack phase=0. A push in the same cycle as FLUSH is discarded.
- SDMA_REQ: registered; 1 when EN && level >= THRESH && level != 0, else 0. It drops the cycle after level falls below THRESH.
- SDMA_DONE pulse sets DONE.
- Reset values:
  - CTRL=0, THRESH=FIFO_DEPTH/2, level=0, pointers=0, pack phase=0, sticky bits=0.
  - Outputs: WBS_ACK=0, WBS_RD_DAT=0, SDMA_REQ=0, FIFO_IRQ=0.
  - Reset mid-transfer aborts the transfer with no ACK; FIFO contents become don't-care.
- Latency:
  - ADC_DATA_VALID to level increment: 1 cycle (the second sample of a pair when packing).
  - Level change to SDMA_REQ: 1 further cycle.

Optional Feature:
ADC_FIFO_PACK_EN
- Defined: two samples per word as above.
- Undefined: each sample pushes one word {16'h0, ADC_DATA}. No pack state exists, and EN-clear only gates ingest.

Test Plan:
1. Reset, then read 0x00/0x04/0x08 -> 0x0, 0x0001_0000, 0x80; SDMA_REQ=0.
2. EN=1, feed samples 0x1111, 0x2222, 0x3333, 0x4444 -> level=2; DATA reads 0x2222_1111 then 0x4444_3333; third read returns 0 with UNF=1.
3. THRESH=4, push 8 samples -> SDMA_REQ rises one cycle after level hits 4; one DATA pop to level 3 -> REQ low next cycle.
4. Fill to 256 words, push 2 more samples -> level=256, full=1, OVF=1; the first pop returns the original first word.
5. Feed 0xAAAA (held half), write CTRL EN=0 then EN=1, feed 0xBBBB, 0xCCCC -> single word 0xCCCC_BBBB.
6. Unmask DONE, pulse SDMA_DONE -> FIFO_IRQ=1; write STATUS bit 24=1 -> FIFO_IRQ=0. Also: push and pop in the same cycle at level 5 -> level stays 5.
